// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types for the DMA bus arbiter: FSM state encoding and counter sizing.
package dma_bus_arbiter_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    CPU_OWN = 3'd0,
    REQ_CPU = 3'd1,
    GRANTED = 3'd2,
    DMA     = 3'd3,
    RECOVER = 3'd4
  } arb_state_e;

  // Width of the shared GRANTED/RECOVER counter: one bit beyond the larger limit,
  // so the counter can saturate without ever wrapping.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Bus arbitration signals between the arbiter, the 68SEC000 and the motherboard.
interface dma_bus_arbiter_if;
  import dma_bus_arbiter_pkg::*;

  logic               BR_n_IN;
  logic               BGACK_n;
  logic               AS_MB_n_IN;
  logic               BG_CPU_n;
  logic               AS_CPU_n;
  logic               BR_CPU_n;
  logic               BG_n_OUT;
  logic               BG_n_OE;
  logic               DMA_ACTIVE;
  logic               TIMEOUT_PULSE;
  logic [STATE_W-1:0] STATE;

  // Arbiter side.
  modport master (
    input  BR_n_IN, BGACK_n, AS_MB_n_IN, BG_CPU_n, AS_CPU_n,
    output BR_CPU_n, BG_n_OUT, BG_n_OE, DMA_ACTIVE, TIMEOUT_PULSE, STATE
  );

  // Board / CPU side.
  modport slave (
    output BR_n_IN, BGACK_n, AS_MB_n_IN, BG_CPU_n, AS_CPU_n,
    input  BR_CPU_n, BG_n_OUT, BG_n_OE, DMA_ACTIVE, TIMEOUT_PULSE, STATE
  );

endinterface

// File: rtl/dma_bus_arbiter_bus_sync.sv
// N-stage synchroniser for one asynchronous, active-low motherboard input.
// Resets to 1 so every line reads as inactive until real samples arrive.
module dma_bus_arbiter_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '1;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/dma_bus_arbiter.sv
// Bus-ownership controller: maps Amiga 3-wire arbitration (BR/BG/BGACK) onto the
// 68SEC000 2-wire BR/BG pair, with input sync, grant timeout and CPU recovery window.
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int GRANT_TIMEOUT  = 256,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic C7M,
  input  logic RESET,
  input  logic DMA_EN,
  dma_bus_arbiter_if.master bus
);

  localparam int CNT_W = cnt_width(GRANT_TIMEOUT, RECOVER_CYCLES);
  localparam logic [CNT_W-1:0] GRANT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REC_LAST   = CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic br_s, bgack_s, as_mb_s;

  dma_bus_arbiter_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_br (
    .clk(C7M), .rst(RESET), .d(bus.BR_n_IN), .q(br_s)
  );
  dma_bus_arbiter_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bgack (
    .clk(C7M), .rst(RESET), .d(bus.BGACK_n), .q(bgack_s)
  );
  dma_bus_arbiter_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_as_mb (
    .clk(C7M), .rst(RESET), .d(bus.AS_MB_n_IN), .q(as_mb_s)
  );

  arb_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             br_cpu_n, bg_n_out, bg_n_oe, dma_active, timeout_pulse;

  // Arbitration FSM with the shared saturating counter and all registered outputs.
  always_ff @(posedge C7M) begin
    if (RESET) begin
      state         <= CPU_OWN;
      cnt           <= '0;
      br_cpu_n      <= 1'b1;
      bg_n_out      <= 1'b1;
      bg_n_oe       <= 1'b0;
      dma_active    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      bg_n_oe       <= DMA_EN;
      unique case (state)
        CPU_OWN: begin
          if (DMA_EN && !br_s) begin
            state    <= REQ_CPU;
            br_cpu_n <= 1'b0;
            cnt      <= '0;
          end
        end
        REQ_CPU: begin
          // A withdrawn request returns straight to the CPU; the CPU never lost the bus.
          if (br_s) begin
            state    <= CPU_OWN;
            br_cpu_n <= 1'b1;
            cnt      <= '0;
          end else if (!DMA_EN) begin
            state    <= RECOVER;
            br_cpu_n <= 1'b1;
            bg_n_out <= 1'b1;
            cnt      <= '0;
          end else if (!bus.BG_CPU_n && bus.AS_CPU_n && as_mb_s) begin
            state    <= GRANTED;
            bg_n_out <= 1'b0;
            cnt      <= '0;
          end
        end
        GRANTED: begin
          // An acknowledge wins over every withdrawal reason, including the timeout edge.
          if (!bgack_s) begin
            state      <= DMA;
            bg_n_out   <= 1'b1;
            dma_active <= 1'b1;
            cnt        <= '0;
          end else if (br_s || !DMA_EN) begin
            state    <= RECOVER;
            br_cpu_n <= 1'b1;
            bg_n_out <= 1'b1;
            cnt      <= '0;
          end else if (cnt == GRANT_LAST) begin
            state         <= RECOVER;
            br_cpu_n      <= 1'b1;
            bg_n_out      <= 1'b1;
            timeout_pulse <= 1'b1;
            cnt           <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DMA: begin
          // End of tenure: hand straight to a waiting master, else give the CPU its window.
          if (bgack_s) begin
            dma_active <= 1'b0;
            cnt        <= '0;
            if (!br_s && DMA_EN) begin
              state    <= GRANTED;
              bg_n_out <= 1'b0;
            end else begin
              state    <= RECOVER;
              br_cpu_n <= 1'b1;
              bg_n_out <= 1'b1;
            end
          end
        end
        RECOVER: begin
          if (cnt == REC_LAST) begin
            state <= CPU_OWN;
            cnt   <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= CPU_OWN;
          br_cpu_n <= 1'b1;
          bg_n_out <= 1'b1;
          cnt      <= '0;
        end
      endcase
    end
  end

  assign bus.BR_CPU_n      = br_cpu_n;
  assign bus.BG_n_OUT      = bg_n_out;
  assign bus.BG_n_OE       = bg_n_oe;
  assign bus.DMA_ACTIVE    = dma_active;
  assign bus.TIMEOUT_PULSE = timeout_pulse;
  assign bus.STATE         = state;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: directed scenarios plus randomized traffic, all
// compared every cycle against a state-level reference model of the arbiter.
module tb_dma_bus_arbiter;

  localparam int SYNC_STAGES    = 2;
  localparam int GRANT_TIMEOUT  = 16;
  localparam int RECOVER_CYCLES = 4;

  localparam logic [2:0] ST_CPU_OWN = 3'd0;
  localparam logic [2:0] ST_REQ_CPU = 3'd1;
  localparam logic [2:0] ST_GRANTED = 3'd2;
  localparam logic [2:0] ST_DMA     = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  logic clk = 1'b0;
  logic rst;
  logic dma_en;
  int   checks = 0;
  int   errors = 0;

  dma_bus_arbiter_if bus_if ();

  dma_bus_arbiter #(
    .SYNC_STAGES(SYNC_STAGES),
    .GRANT_TIMEOUT(GRANT_TIMEOUT),
    .RECOVER_CYCLES(RECOVER_CYCLES)
  ) dut (
    .C7M(clk),
    .RESET(rst),
    .DMA_EN(dma_en),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: ownership phase plus cycle budgets; outputs follow from the phase.
  logic [2:0] m_state;
  logic       m_oe, m_pulse;
  int         m_age, m_left;
  logic       q_br[$], q_bgack[$], q_asmb[$];
  logic       br_s, bgack_s, asmb_s;

  always @(posedge clk) begin
    if (rst) begin
      m_state = ST_CPU_OWN;
      m_oe    = 1'b0;
      m_pulse = 1'b0;
      m_age   = 0;
      m_left  = 0;
      q_br.delete();
      q_bgack.delete();
      q_asmb.delete();
      for (int i = 0; i < SYNC_STAGES; i++) begin
        q_br.push_back(1'b1);
        q_bgack.push_back(1'b1);
        q_asmb.push_back(1'b1);
      end
    end else begin
      br_s    = q_br.pop_front();
      bgack_s = q_bgack.pop_front();
      asmb_s  = q_asmb.pop_front();
      q_br.push_back(bus_if.BR_n_IN);
      q_bgack.push_back(bus_if.BGACK_n);
      q_asmb.push_back(bus_if.AS_MB_n_IN);
      m_pulse = 1'b0;
      case (m_state)
        ST_CPU_OWN: if (dma_en && !br_s) m_state = ST_REQ_CPU;
        ST_REQ_CPU: begin
          if (br_s) m_state = ST_CPU_OWN;
          else if (!dma_en) begin m_state = ST_RECOVER; m_left = RECOVER_CYCLES; end
          else if (!bus_if.BG_CPU_n && bus_if.AS_CPU_n && asmb_s) begin
            m_state = ST_GRANTED; m_age = 1;
          end
        end
        ST_GRANTED: begin
          if (!bgack_s) m_state = ST_DMA;
          else if (br_s || !dma_en) begin m_state = ST_RECOVER; m_left = RECOVER_CYCLES; end
          else if (m_age == GRANT_TIMEOUT) begin
            m_state = ST_RECOVER; m_left = RECOVER_CYCLES; m_pulse = 1'b1;
          end else m_age++;
        end
        ST_DMA: begin
          if (bgack_s) begin
            if (!br_s && dma_en) begin m_state = ST_GRANTED; m_age = 1; end
            else begin m_state = ST_RECOVER; m_left = RECOVER_CYCLES; end
          end
        end
        ST_RECOVER: begin
          if (m_left == 1) m_state = ST_CPU_OWN;
          else m_left--;
        end
        default: m_state = ST_CPU_OWN;
      endcase
      m_oe = dma_en;
    end
  end

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("m_br_cpu_n", 3'(bus_if.BR_CPU_n),
        3'(!(m_state == ST_REQ_CPU || m_state == ST_GRANTED || m_state == ST_DMA)));
    chk("m_bg_n_out", 3'(bus_if.BG_n_OUT), 3'(m_state != ST_GRANTED));
    chk("m_bg_n_oe", 3'(bus_if.BG_n_OE), 3'(m_oe));
    chk("m_dma_active", 3'(bus_if.DMA_ACTIVE), 3'(m_state == ST_DMA));
    chk("m_timeout_pulse", 3'(bus_if.TIMEOUT_PULSE), 3'(m_pulse));
    chk("m_state", bus_if.STATE, m_state);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk_model();
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    dma_en = 1'b0;
    bus_if.BR_n_IN = 1'b1;
    bus_if.BGACK_n = 1'b1;
    bus_if.AS_MB_n_IN = 1'b1;
    bus_if.BG_CPU_n = 1'b1;
    bus_if.AS_CPU_n = 1'b1;
    tick();
    tick();
    chk("rst_br_cpu_n", 3'(bus_if.BR_CPU_n), 3'd1);
    chk("rst_bg_n_out", 3'(bus_if.BG_n_OUT), 3'd1);
    chk("rst_bg_n_oe", 3'(bus_if.BG_n_OE), 3'd0);
    chk("rst_dma_active", 3'(bus_if.DMA_ACTIVE), 3'd0);
    chk("rst_timeout", 3'(bus_if.TIMEOUT_PULSE), 3'd0);
    chk("rst_state", bus_if.STATE, ST_CPU_OWN);
    rst = 1'b0;

    // Scenario 1: full request / grant / acknowledge sequence.
    dma_en = 1'b1;
    tick();
    chk("s1_bg_n_oe", 3'(bus_if.BG_n_OE), 3'd1);
    bus_if.BR_n_IN = 1'b0;
    tick();
    tick();
    chk("s1_br_cpu_n_c2", 3'(bus_if.BR_CPU_n), 3'd1);
    tick();
    chk("s1_br_cpu_n_c3", 3'(bus_if.BR_CPU_n), 3'd0);
    tick();
    tick();
    bus_if.BG_CPU_n = 1'b0;
    tick();
    chk("s1_bg_n_out_low", 3'(bus_if.BG_n_OUT), 3'd0);
    chk("s1_state_granted", bus_if.STATE, ST_GRANTED);
    repeat (4) tick();
    bus_if.BGACK_n = 1'b0;
    tick();
    tick();
    chk("s1_dma_active_early", 3'(bus_if.DMA_ACTIVE), 3'd0);
    tick();
    chk("s1_dma_active", 3'(bus_if.DMA_ACTIVE), 3'd1);
    chk("s1_bg_n_out_high", 3'(bus_if.BG_n_OUT), 3'd1);
    chk("s1_state_dma", bus_if.STATE, ST_DMA);

    // Scenario 4: second master keeps BR low as the first releases BGACK.
    bus_if.BGACK_n = 1'b1;
    tick();
    tick();
    tick();
    chk("s4_state_granted", bus_if.STATE, ST_GRANTED);
    chk("s4_bg_n_out", 3'(bus_if.BG_n_OUT), 3'd0);
    chk("s4_br_cpu_n", 3'(bus_if.BR_CPU_n), 3'd0);
    chk("s4_dma_active", 3'(bus_if.DMA_ACTIVE), 3'd0);
    bus_if.BGACK_n = 1'b0;
    repeat (4) tick();
    bus_if.BR_n_IN = 1'b1;
    bus_if.BGACK_n = 1'b1;
    bus_if.BG_CPU_n = 1'b1;
    repeat (3) tick();
    chk("s4_state_recover", bus_if.STATE, ST_RECOVER);
    repeat (8) tick();

    // Scenario 2: grant never acknowledged, timeout withdraws it.
    bus_if.BR_n_IN = 1'b0;
    repeat (3) tick();
    chk("s2_state_req", bus_if.STATE, ST_REQ_CPU);
    bus_if.BG_CPU_n = 1'b0;
    tick();
    chk("s2_bg_n_out_low", 3'(bus_if.BG_n_OUT), 3'd0);
    repeat (15) tick();
    chk("s2_state_still_granted", bus_if.STATE, ST_GRANTED);
    chk("s2_no_pulse_yet", 3'(bus_if.TIMEOUT_PULSE), 3'd0);
    tick();
    chk("s2_timeout_pulse", 3'(bus_if.TIMEOUT_PULSE), 3'd1);
    chk("s2_bg_n_out_high", 3'(bus_if.BG_n_OUT), 3'd1);
    chk("s2_br_cpu_n_high", 3'(bus_if.BR_CPU_n), 3'd1);
    chk("s2_state_recover", bus_if.STATE, ST_RECOVER);
    tick();
    chk("s2_pulse_one_cycle", 3'(bus_if.TIMEOUT_PULSE), 3'd0);
    repeat (3) tick();
    chk("s2_state_cpu_own", bus_if.STATE, ST_CPU_OWN);
    bus_if.BR_n_IN = 1'b1;
    bus_if.BG_CPU_n = 1'b1;
    repeat (8) tick();

    // Same-cycle timeout edge and acknowledge: acknowledge wins.
    bus_if.BR_n_IN = 1'b0;
    repeat (3) tick();
    bus_if.BG_CPU_n = 1'b0;
    tick();
    repeat (13) tick();
    bus_if.BGACK_n = 1'b0;
    repeat (3) tick();
    chk("edge_state_dma", bus_if.STATE, ST_DMA);
    chk("edge_no_pulse", 3'(bus_if.TIMEOUT_PULSE), 3'd0);
    chk("edge_dma_active", 3'(bus_if.DMA_ACTIVE), 3'd1);
    bus_if.BR_n_IN = 1'b1;
    bus_if.BGACK_n = 1'b1;
    bus_if.BG_CPU_n = 1'b1;
    repeat (10) tick();

    // Scenario 3: a one-cycle BR glitch must never produce a grant.
    bus_if.BG_CPU_n = 1'b0;
    seen = 0;
    bus_if.BR_n_IN = 1'b0;
    tick();
    bus_if.BR_n_IN = 1'b1;
    repeat (8) begin
      tick();
      if (bus_if.BG_n_OUT !== 1'b1) seen++;
    end
    chk("s3_no_grant", 3'(seen), 3'd0);
    bus_if.BG_CPU_n = 1'b1;
    repeat (4) tick();

    // Scenario 5: arbitration disabled, then DMA_EN dropped while granted.
    dma_en = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      bus_if.BR_n_IN = 1'($urandom_range(0, 1));
      tick();
      chk("s5_br_cpu_n", 3'(bus_if.BR_CPU_n), 3'd1);
      chk("s5_bg_n_oe", 3'(bus_if.BG_n_OE), 3'd0);
    end
    bus_if.BR_n_IN = 1'b1;
    repeat (4) tick();
    dma_en = 1'b1;
    bus_if.BR_n_IN = 1'b0;
    repeat (3) tick();
    bus_if.BG_CPU_n = 1'b0;
    tick();
    chk("s5_state_granted", bus_if.STATE, ST_GRANTED);
    tick();
    dma_en = 1'b0;
    tick();
    chk("s5_drop_recover", bus_if.STATE, ST_RECOVER);
    chk("s5_drop_bg_high", 3'(bus_if.BG_n_OUT), 3'd1);
    bus_if.BR_n_IN = 1'b1;
    bus_if.BG_CPU_n = 1'b1;
    repeat (6) tick();
    dma_en = 1'b1;

    // Scenario 6: reset in the middle of a DMA tenure.
    bus_if.BR_n_IN = 1'b0;
    repeat (3) tick();
    bus_if.BG_CPU_n = 1'b0;
    tick();
    bus_if.BGACK_n = 1'b0;
    repeat (3) tick();
    chk("s6_state_dma", bus_if.STATE, ST_DMA);
    rst = 1'b1;
    tick();
    chk("s6_br_cpu_n", 3'(bus_if.BR_CPU_n), 3'd1);
    chk("s6_bg_n_out", 3'(bus_if.BG_n_OUT), 3'd1);
    chk("s6_bg_n_oe", 3'(bus_if.BG_n_OE), 3'd0);
    chk("s6_dma_active", 3'(bus_if.DMA_ACTIVE), 3'd0);
    chk("s6_state", bus_if.STATE, ST_CPU_OWN);
    rst = 1'b0;
    bus_if.BR_n_IN = 1'b1;
    bus_if.BGACK_n = 1'b1;
    bus_if.BG_CPU_n = 1'b1;
    tick();
    chk("s6_after_release", bus_if.STATE, ST_CPU_OWN);

    // Randomized traffic: slowly toggling lines so tenures, chains and timeouts occur.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bus_if.BR_n_IN = ~bus_if.BR_n_IN;
      if ($urandom_range(0, 9) == 0) bus_if.BGACK_n = ~bus_if.BGACK_n;
      if ($urandom_range(0, 5) == 0) bus_if.AS_MB_n_IN = ~bus_if.AS_MB_n_IN;
      if ($urandom_range(0, 3) == 0) bus_if.BG_CPU_n = ~bus_if.BG_CPU_n;
      if ($urandom_range(0, 3) == 0) bus_if.AS_CPU_n = ~bus_if.AS_CPU_n;
      if ($urandom_range(0, 63) == 0) dma_en = ~dma_en;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
